// File: rtl/sap_pkg.sv
// Shared types for the datapath/register-file slice: ALU opcodes (OP_MUL
// included so the encoding is the same whether or not the multiplier is
// built), the {z,n,c,v} flag struct and the controller state enum.
package sap_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5
  } alu_op_e;

  // Packed as {z,n,c,v} so it maps directly onto the 4-bit flags port.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle ALU: add/sub/and/or/xor with z,n,c,v flags.
// For SUB, c is the borrow (set when a < b unsigned).
// OP_MUL is not handled here; the shift-add multiplier lives in the top.
module alu import sap_pkg::*; #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  alu_op_e      op_i,
  output logic [N-1:0] y_o,
  output flags_t       flags_o
);

  logic [N:0] wide;

  // Result with one extra bit to capture carry/borrow, then derive flags
  always_comb begin
    wide    = '0;
    flags_o = '0;
    case (op_i)
      OP_ADD: begin
        wide      = {1'b0, a_i} + {1'b0, b_i};
        flags_o.c = wide[N];
        flags_o.v = (a_i[N-1] == b_i[N-1]) && (wide[N-1] != a_i[N-1]);
      end
      OP_SUB: begin
        wide      = {1'b0, a_i} - {1'b0, b_i};
        flags_o.c = wide[N];
        flags_o.v = (a_i[N-1] != b_i[N-1]) && (wide[N-1] != a_i[N-1]);
      end
      OP_AND:  wide = {1'b0, a_i & b_i};
      OP_OR:   wide = {1'b0, a_i | b_i};
      OP_XOR:  wide = {1'b0, a_i ^ b_i};
      default: wide = '0;
    endcase
    flags_o.z = (wide[N-1:0] == '0);
    flags_o.n = wide[N-1];
  end

  assign y_o = wide[N-1:0];

endmodule

// File: rtl/reg_file.sv
// NREG x N register array, two combinational read ports, one write port.
// Indices >= NREG read as zero and are ignored on write.
module reg_file #(
  parameter int N    = 8,
  parameter int NREG = 4,
  localparam int AW  = ($clog2(NREG) > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra_i,
  input  logic [AW-1:0] rb_i,
  output logic [N-1:0]  rd_a_o,
  output logic [N-1:0]  rd_b_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [N-1:0]  wd_i
);

  logic [N-1:0] regs_q [NREG];

  // Registers clear on reset; in-range writes land at the clock edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (int'(wa_i) < NREG)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = (int'(ra_i) < NREG) ? regs_q[ra_i] : '0;
  assign rd_b_o = (int'(rb_i) < NREG) ? regs_q[rb_i] : '0;

endmodule

// File: rtl/datapath_rf.sv
// Register-file datapath: load / single-cycle ALU commands, a one-entry
// output buffer with valid/ready pop, and an optional N-cycle shift-add
// multiplier built when the macro DP_MUL_EN is defined. Without DP_MUL_EN
// an accepted OP_MUL is consumed in one cycle with no side effects.
//
// Handshakes: a command transfers on a rising edge with cmd_valid &&
// cmd_ready; the output buffer entry transfers on a rising edge with
// out_valid && out_ready. cmd_ready is withheld while the multiplier runs
// or while the buffer is full and not being drained, so every push has room.
module datapath_rf import sap_pkg::*; #(
  parameter int N    = 8,
  parameter int NREG = 4,
  localparam int AW  = ($clog2(NREG) > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  alu_op_e       op,
  input  logic          ld,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  input  logic [AW-1:0] dst,
  input  logic          sel_imm,
  input  logic [N-1:0]  bus_in,
  input  logic [N-1:0]  imm_data,
  input  logic          out_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [3:0]    flags,
  output logic          busy,
  output logic          dbg_state
);

  state_e        state_q;
  flags_t        flags_q, alu_flags, mul_flags;
  logic          out_valid_q;
  logic [N-1:0]  out_data_q;
  logic [N-1:0]  rd_a, rd_b, opnd_b, alu_y, cmd_res, push_data;
  logic          accept, single_wr, alu_wr, push;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [N-1:0]  rf_wd;
  logic          mul_done, mul_out;
  logic [AW-1:0] mul_dst;
  logic [N-1:0]  mul_lo;

  reg_file #(.N(N), .NREG(NREG)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .ra_i   (src_a),
    .rb_i   (src_b),
    .rd_a_o (rd_a),
    .rd_b_o (rd_b),
    .we_i   (rf_we),
    .wa_i   (rf_wa),
    .wd_i   (rf_wd)
  );

  alu #(.N(N)) u_alu (
    .a_i     (rd_a),
    .b_i     (opnd_b),
    .op_i    (op),
    .y_o     (alu_y),
    .flags_o (alu_flags)
  );

  assign cmd_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = cmd_valid && cmd_ready;
  // Loads and non-multiply ALU ops retire at the accept edge.
  assign single_wr = accept && (ld || (op != OP_MUL));
  assign alu_wr    = accept && !ld && (op != OP_MUL);
  assign opnd_b    = sel_imm ? imm_data : rd_b;
  assign cmd_res   = ld ? bus_in : alu_y;

`ifdef DP_MUL_EN
  localparam int CW = $clog2(N);

  logic [N-1:0]  mcand_q, hi_q, lo_q, hi_d, lo_d;
  logic [AW-1:0] mdst_q;
  logic          mout_q;
  logic [CW-1:0] cnt_q;
  logic [N:0]    mul_sum;
  logic          mul_start;

  assign mul_start = accept && !ld && (op == OP_MUL);
  // One shift-add step: conditionally add the multiplicand to the high half,
  // then shift {carry, hi, lo} right by one.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign hi_d      = mul_sum[N:1];
  assign lo_d      = {mul_sum[0], lo_q[N-1:1]};
  assign mul_done  = (state_q == MUL) && (cnt_q == CW'(N - 1));
  assign mul_lo    = lo_d;
  assign mul_dst   = mdst_q;
  assign mul_out   = mout_q;
  assign mul_flags = {(lo_d == '0), lo_d[N-1], |hi_d, |hi_d};
  assign busy      = (state_q == MUL);

  // Controller FSM and multiplier operand/step registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mdst_q  <= '0;
      mout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mul_start) begin
            state_q <= MUL;
            cnt_q   <= '0;
            mcand_q <= rd_a;
            hi_q    <= '0;
            lo_q    <= opnd_b;
            mdst_q  <= dst;
            mout_q  <= out_en;
          end
        end
        MUL: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (mul_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  // No multiplier: the controller never leaves IDLE.
  assign state_q   = IDLE;
  assign mul_done  = 1'b0;
  assign mul_lo    = '0;
  assign mul_dst   = '0;
  assign mul_out   = 1'b0;
  assign mul_flags = '0;
  assign busy      = 1'b0;
`endif

  // Register write port: single-cycle result, or multiplier writeback
  always_comb begin
    rf_we = single_wr;
    rf_wa = dst;
    rf_wd = cmd_res;
    if (mul_done) begin
      rf_we = 1'b1;
      rf_wa = mul_dst;
      rf_wd = mul_lo;
    end
  end

  assign push      = (single_wr && out_en) || (mul_done && mul_out);
  assign push_data = mul_done ? mul_lo : cmd_res;

  // Flag register and one-entry output buffer (push wins over pop)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (alu_wr)        flags_q <= alu_flags;
      else if (mul_done) flags_q <= mul_flags;
      if (push) begin
        out_valid_q <= 1'b1;
        out_data_q  <= push_data;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign flags     = flags_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_datapath_rf.sv
// Directed bench for datapath_rf (N=8, NREG=4). Covers the multiplier
// tests when DP_MUL_EN is defined, the one-cycle OP_MUL no-op otherwise.
module tb_datapath_rf;
  import sap_pkg::*;

  localparam int N    = 8;
  localparam int NREG = 4;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  alu_op_e       op;
  logic          ld, sel_imm, out_en;
  logic [AW-1:0] src_a, src_b, dst;
  logic [N-1:0]  bus_in, imm_data;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_data;
  logic [3:0]    flags;
  logic          busy, dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  datapath_rf #(.N(N), .NREG(NREG)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .op        (op),
    .ld        (ld),
    .src_a     (src_a),
    .src_b     (src_b),
    .dst       (dst),
    .sel_imm   (sel_imm),
    .bus_in    (bus_in),
    .imm_data  (imm_data),
    .out_en    (out_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flags     (flags),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: all start and end just after a falling edge
  task automatic drive_idle();
    cmd_valid = 1'b0; ld = 1'b0; op = OP_ADD; src_a = '0; src_b = '0; dst = '0;
    sel_imm = 1'b0; bus_in = '0; imm_data = '0; out_en = 1'b0;
  endtask

  task automatic issue(input logic l, input alu_op_e o, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [AW-1:0] d, input logic si,
                       input logic [N-1:0] bus, input logic [N-1:0] imm, input logic oe);
    int waits = 0;
    ld = l; op = o; src_a = a; src_b = b; dst = d; sel_imm = si;
    bus_in = bus; imm_data = imm; out_en = oe; cmd_valid = 1'b1;
    while (!cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
  endtask

  task automatic do_ld(input logic [AW-1:0] d, input logic [N-1:0] v, input logic oe);
    issue(1'b1, OP_ADD, '0, '0, d, 1'b0, v, '0, oe);
  endtask

  task automatic do_alu(input alu_op_e o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] d, input logic si, input logic [N-1:0] imm,
                        input logic oe);
    issue(1'b0, o, a, b, d, si, '0, imm, oe);
  endtask

  // scoreboard: compare the buffer head against the oldest expectation
  task automatic check_out(input string tag);
    check({tag, "_valid"}, out_valid, 1);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got 0x%0h expected <none queued>", tag, out_data);
    end else begin
      check({tag, "_data"}, out_data, exp_q.pop_front());
    end
  endtask

  // read a register back by OR-ing it with immediate 0 into itself
  task automatic read_reg(input logic [AW-1:0] idx, input logic [N-1:0] exp, input string tag);
    exp_q.push_back(exp);
    do_alu(OP_OR, idx, '0, idx, 1'b1, 8'h00, 1'b1);
    check_out(tag);
  endtask

  initial begin
    drive_idle();
    out_ready = 1'b1;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_flags", flags, 4'b0000);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_state", dbg_state, IDLE);

    // load test: 5 + 3
    do_ld(2'd1, 8'h05, 1'b0);
    do_ld(2'd2, 8'h03, 1'b0);
    exp_q.push_back(8'h08);
    do_alu(OP_ADD, 2'd1, 2'd2, 2'd0, 1'b0, '0, 1'b1);
    check_out("add_load");
    check("add_load_flags", flags, 4'b0000);

    // signed overflow: 0x7F + imm 0x01
    do_ld(2'd1, 8'h7F, 1'b0);
    exp_q.push_back(8'h80);
    do_alu(OP_ADD, 2'd1, '0, 2'd3, 1'b1, 8'h01, 1'b1);
    check_out("add_ovf");
    check("add_ovf_flags", flags, 4'b0101);
    do_ld(2'd2, 8'h00, 1'b0);
    check("ld_keeps_flags", flags, 4'b0101);

    // subtract with borrow: 0x00 - 0x01
    exp_q.push_back(8'hFF);
    do_alu(OP_SUB, 2'd2, '0, 2'd2, 1'b1, 8'h01, 1'b1);
    check_out("sub_borrow");
    check("sub_borrow_flags", flags, 4'b0110);

    // zero result: x ^ x
    exp_q.push_back(8'h00);
    do_alu(OP_XOR, 2'd1, 2'd1, 2'd1, 1'b0, '0, 1'b1);
    check_out("xor_zero");
    check("xor_zero_flags", flags, 4'b1000);

    // src == dst reads the pre-edge value: 0x40 + 0x40
    do_ld(2'd1, 8'h40, 1'b0);
    exp_q.push_back(8'h80);
    do_alu(OP_ADD, 2'd1, 2'd1, 2'd1, 1'b0, '0, 1'b1);
    check_out("add_self");
    check("add_self_flags", flags, 4'b0101);
    read_reg(2'd1, 8'h80, "rd_r1");
    read_reg(2'd3, 8'h80, "rd_r3");

    // back-pressure: full buffer blocks commands; pop+push keeps valid
    @(negedge clk);
    check("bp_drained", out_valid, 0);
    out_ready = 1'b0;
    exp_q.push_back(8'h5A);
    do_ld(2'd0, 8'h5A, 1'b1);
    check_out("bp_first");
    check("bp_blocked", cmd_ready, 0);
    @(negedge clk);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_data", out_data, 8'h5A);
    check("bp_still_blocked", cmd_ready, 0);
    out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    do_ld(2'd0, 8'hA5, 1'b1);
    check_out("bp_swap");
    @(negedge clk);
    check("bp_popped", out_valid, 0);

`ifdef DP_MUL_EN
    // multiply 0x10 * 0x11 = 0x110; another command held valid meanwhile
    do_ld(2'd1, 8'h10, 1'b0);
    do_ld(2'd2, 8'h11, 1'b0);
    ld = 1'b0; op = OP_MUL; src_a = 2'd1; src_b = 2'd2; dst = 2'd3; out_en = 1'b1;
    cmd_valid = 1'b1;
    check("mul_accept_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    ld = 1'b1; dst = 2'd0; bus_in = 8'h77; out_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("mul_busy", busy, 1);
      check("mul_hold_ready", cmd_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
    check("mul_busy_end", busy, 0);
    check("mul_ready_end", cmd_ready, 1);
    exp_q.push_back(8'h10);
    check_out("mul_out");
    check("mul_flags", flags, 4'b0011);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    read_reg(2'd0, 8'h77, "rd_held_ld");
    read_reg(2'd3, 8'h10, "rd_mul_dst");

    // reset during cycle 3 of a multiply
    do_alu(OP_SUB, 2'd0, '0, 2'd0, 1'b1, 8'h78, 1'b0);
    check("pre_rst_flags", flags, 4'b0110);
    ld = 1'b0; op = OP_MUL; src_a = 2'd1; src_b = 2'd2; dst = 2'd2; out_en = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    check("mul2_busy", busy, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mulrst_busy", busy, 0);
    check("mulrst_flags", flags, 4'b0000);
    check("mulrst_state", dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b0;
    check("mulrst_ready", cmd_ready, 1);
    read_reg(2'd2, 8'h00, "rd_mulrst_dst");
`else
    // OP_MUL without the multiplier: consumed, no side effects
    do_ld(2'd1, 8'h10, 1'b0);
    do_ld(2'd2, 8'h11, 1'b0);
    do_alu(OP_MUL, 2'd1, 2'd2, 2'd3, 1'b0, '0, 1'b1);
    check("nomul_busy", busy, 0);
    check("nomul_no_push", out_valid, 0);
    check("nomul_flags", flags, 4'b0100);
    check("nomul_ready", cmd_ready, 1);
    read_reg(2'd3, 8'h80, "rd_nomul_dst");

    // asynchronous reset between edges
    reset = 1'b1;
    #1;
    check("arst_flags", flags, 4'b0000);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 8'h00);
    check("arst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    check("arst_ready", cmd_ready, 1);
    read_reg(2'd1, 8'h00, "rd_arst_r1");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_rf.md
DATAPATH_RF -- requirements
Module: datapath_rf

Interface
REQ-001 Parameter N, default 8, data width in bits (N >= 4).
REQ-002 Parameter NREG, default 4, number of general registers (NREG >= 2); AW = max(1, clog2(NREG)).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present; cmd_ready  output  1  command can be accepted.
REQ-006 op  input  alu_op_e  ALU operation; ld  input  1  load command (dst <= bus_in, no ALU).
REQ-007 src_a, src_b, dst  input  AW each  register indices; sel_imm  input  1  ALU operand B = imm_data instead of R[src_b].
REQ-008 bus_in, imm_data  input  N each  load data and immediate operand.
REQ-009 out_en  input  1  also push the command result into the output buffer.
REQ-010 out_valid  output  1, out_ready  input  1, out_data  output  N  output-buffer handshake.
REQ-011 flags  output  4  registered {z,n,c,v}; busy  output  1  multi-cycle operation in progress.

Function
REQ-012 A command is accepted at the rising edge where cmd_valid && cmd_ready.
REQ-013 cmd_ready SHALL equal (state == IDLE) && (!out_valid || out_ready).
REQ-014 ALU operands: A = R[src_a], B = sel_imm ? imm_data : R[src_b], read combinationally from pre-edge contents.
REQ-015 Single-cycle command: the result is written to R[dst] at the accept edge and is readable in the following cycle.
REQ-016 ALU commands update flags at the write edge; ld commands leave flags unchanged.
REQ-017 When out_en is set, out_data captures the result and out_valid is 1 from the write edge onward.
REQ-018 out_valid clears on an edge with out_valid && out_ready and no push; push plus pop on the same edge keeps out_valid = 1 with the new data.
REQ-019 src equal to dst reads the old value; a dst index >= NREG is ignored for writes, and reads of an index >= NREG return 0.
REQ-020 States: IDLE and MUL. MUL is entered only on acceptance of OP_MUL and is left after exactly N cycles in MUL.
REQ-021 In MUL, busy = 1 and cmd_ready = 0; an N-step shift-add runs on latched operands, dst and out_en.
REQ-022 MUL writeback: R[dst] <= low N bits of the product; c = v = (high N bits != 0); z and n come from the low N bits.
REQ-023 MUL latency: accepted at edge 0, result written at edge N, cmd_ready high after edge N if the output buffer permits.
REQ-024 A MUL with out_en pushes the result only at edge N; out_ready stalls do not stall the multiplier (REQ-013 guarantees space at edge N).

Reset
REQ-025 When reset is asserted, all R[i] = 0, flags = 0, out_data = 0, out_valid = 0, state = IDLE, busy = 0; this takes effect immediately, independent of clk.
REQ-026 Reset during MUL aborts the operation with no register or flag write.
REQ-027 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 Macro DP_MUL_EN: when defined, OP_MUL and the MUL state are built as specified above.
REQ-029 When DP_MUL_EN is not defined, an accepted OP_MUL is consumed in one cycle with no register, flag or output-buffer update, and busy is tied to 0.

Structure
REQ-030 Shared package sap_pkg holds alu_op_e (including OP_MUL), the flag struct {z,n,c,v} and the state enum.
REQ-031 The register array with 2 read ports and 1 write port is the sub-module reg_file (parameters N, NREG); the existing alu is reused for single-cycle ops.

Verification
REQ-032 Load test: ld R1 <= 0x05 and ld R2 <= 0x03, then ADD dst=R0 with out_en -> out_data = 0x08, flags = 0000, out_valid = 1.
REQ-033 Overflow test: R1 = 0x7F, ADD with imm 0x01 -> R[dst] = 0x80, flags n = 1, v = 1, c = 0, z = 0.
REQ-034 Multiply test (DP_MUL_EN): 0x10 * 0x11 -> busy high for 8 cycles, R[dst] = 0x10, c = v = 1; a command held valid during MUL is not accepted until after edge 8.
REQ-035 Back-pressure test: out_ready = 0 with out_valid = 1 -> cmd_ready = 0; then raise out_ready with a new out_en command -> simultaneous pop and push, out_valid stays 1 with the new data.
REQ-036 Reset test: assert reset at cycle 3 of a MUL -> busy = 0, dst unchanged, flags = 0, cmd_ready = 1 the cycle after release.
